// File: rtl/pwm_capture.sv
// PWM receiver: samples an active-low PWM line and recovers its 8-bit duty once per period.
// Also flags malformed periods and stuck-low lines, and tracks lock to a valid periodic signal.
module pwm_capture #(
    parameter int PERIOD      = 256,
    parameter int TOL         = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [7:0] duty,
    output logic       duty_valid,
    output logic       locked,
    output logic       period_err
);

    localparam int CW = $clog2(PERIOD + TOL + 1);
    localparam logic [CW-1:0] C_MAX    = CW'(PERIOD + TOL);
    localparam logic [CW-1:0] C_PER_M1 = CW'(PERIOD - 1);
    localparam logic [CW-1:0] C_255    = CW'(255);
    localparam logic [CW:0]   P_LO     = (CW + 1)'(PERIOD - TOL);
    localparam logic [CW:0]   P_HI     = (CW + 1)'(PERIOD + TOL);

    typedef enum logic [1:0] {S_SYNC, S_LOW, S_HIGH, S_FLAT_HI} state_t;

    logic [1:0]             r_rst_pipe;
    logic                   w_rst;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_cur, w_fall, w_rise;
    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_low_cnt, w_low_nxt;
    logic [CW-1:0]          r_high_cnt, w_high_nxt;
    logic [CW:0]            w_period;
    logic [7:0]             r_duty, w_duty_nxt;
    logic                   r_valid, w_valid_nxt;
    logic                   r_locked, w_locked_nxt;
    logic                   r_err, w_err_nxt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == C_MAX) ? c : c + 1'b1;
    endfunction

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rst_pipe <= 2'b11;
        else     r_rst_pipe <= {r_rst_pipe[0], 1'b0};
    end
    assign w_rst = r_rst_pipe[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_cur    = r_sync[SYNC_STAGES-1];
    assign w_fall   = r_prev & ~w_cur;
    assign w_rise   = ~r_prev & w_cur;
    assign w_period = {1'b0, r_low_cnt} + {1'b0, r_high_cnt};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_low_nxt    = r_low_cnt;
        w_high_nxt   = r_high_cnt;
        w_duty_nxt   = r_duty;
        w_valid_nxt  = 1'b0;
        w_err_nxt    = 1'b0;
        w_locked_nxt = r_locked;
        case (r_state)
            S_SYNC: begin
                if (w_fall) begin
                    w_low_nxt   = CW'(1);
                    w_state_nxt = S_LOW;
                end else if (!w_cur) begin
                    w_high_nxt = '0;
                end else if (r_high_cnt == C_PER_M1) begin
                    w_high_nxt  = '0;
                    w_state_nxt = S_FLAT_HI;
                end else begin
                    w_high_nxt = sat_inc(r_high_cnt);
                end
            end
            S_LOW: begin
                if (w_rise) begin
                    w_high_nxt  = CW'(1);
                    w_state_nxt = S_HIGH;
                end else if (r_low_cnt == C_MAX) begin
                    w_err_nxt    = 1'b1;
                    w_locked_nxt = 1'b0;
                    w_low_nxt    = '0;
                    w_high_nxt   = '0;
                    w_state_nxt  = S_SYNC;
                end else begin
                    w_low_nxt = sat_inc(r_low_cnt);
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    // The fall closes this period and opens the next one.
                    if (w_period >= P_LO && w_period <= P_HI) begin
                        w_duty_nxt   = (r_low_cnt > C_255) ? 8'hFF : r_low_cnt[7:0];
                        w_valid_nxt  = 1'b1;
                        w_locked_nxt = 1'b1;
                    end else begin
                        w_err_nxt    = 1'b1;
                        w_locked_nxt = 1'b0;
                    end
                    w_low_nxt   = CW'(1);
                    w_state_nxt = S_LOW;
                end else if (r_high_cnt == C_MAX) begin
                    w_duty_nxt   = 8'd0;
                    w_valid_nxt  = 1'b1;
                    w_locked_nxt = 1'b1;
                    w_high_nxt   = '0;
                    w_state_nxt  = S_FLAT_HI;
                end else begin
                    w_high_nxt = sat_inc(r_high_cnt);
                end
            end
            S_FLAT_HI: begin
                if (w_fall) begin
                    w_low_nxt   = CW'(1);
                    w_state_nxt = S_LOW;
                end else if (r_high_cnt == C_PER_M1) begin
                    w_duty_nxt   = 8'd0;
                    w_valid_nxt  = 1'b1;
                    w_locked_nxt = 1'b1;
                    w_high_nxt   = '0;
                end else begin
                    w_high_nxt = sat_inc(r_high_cnt);
                end
            end
            default: w_state_nxt = S_SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_state    <= S_SYNC;
            r_low_cnt  <= '0;
            r_high_cnt <= '0;
            r_duty     <= 8'd0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_low_cnt  <= w_low_nxt;
            r_high_cnt <= w_high_nxt;
            r_duty     <= w_duty_nxt;
            r_valid    <= w_valid_nxt;
            r_locked   <= w_locked_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign duty       = r_duty;
    assign duty_valid = r_valid;
    assign locked     = r_locked;
    assign period_err = r_err;

endmodule
